neuron_unit_fp: RTL and testbench



---
 rtl/neuron_unit_fp.sv | 140 ++++++++++++++
 tb/tb_neuron_unit_fp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_unit_fp.sv
// Fixed-weight binary32 neuron: reduces a captured 7x7 window to sum, horizontal,
// vertical and diagonal features using four sequential accumulators.
module neuron_unit_fp (
    input  logic         clk,
    input  logic         reset,
    input  logic         de_in,
    input  logic [223:0] line_0_in,
    input  logic [223:0] line_1_in,
    input  logic [223:0] line_2_in,
    input  logic [223:0] line_3_in,
    input  logic [223:0] line_4_in,
    input  logic [223:0] line_5_in,
    input  logic [223:0] line_6_in,
    output logic [31:0]  symbol_0,
    output logic [31:0]  symbol_1,
    output logic [31:0]  symbol_2,
    output logic [31:0]  symbol_3
);
    typedef enum logic {IDLE, ACC} state_t;

    state_t                  state_q;
    logic [6:0][6:0][31:0]   win_q, win_in;
    logic [6:0][223:0]       lines;
    logic [2:0]              r_q, c_q;
    logic                    nan_q, in_nan;
    logic [3:0][31:0]        acc_q, acc_d, sym_q;
    logic [3:0]              use_w, neg_w;
    logic [31:0]             x;
    logic                    diag, anti;

    // Round-to-nearest-even add with flush-to-zero; 3 extra bits hold guard/round/sticky.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big, sml;
        logic [7:0]        d;
        logic [26:0]       xl, xs, xs_sh, m27;
        logic [27:0]       s28;
        logic [24:0]       m25;
        logic [22:0]       frac;
        logic signed [9:0] e;
        logic [4:0]        lz;
        if (&a[30:23]) begin
            if (&b[30:23] && (a[31] != b[31])) return 32'h7FC00000;
            return a;
        end
        if (&b[30:23]) return b;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return 32'd0;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
        else begin big = b; sml = a; end
        d  = big[30:23] - sml[30:23];
        xl = {1'b1, big[22:0], 3'b000};
        xs = {1'b1, sml[22:0], 3'b000};
        if (d >= 8'd27) xs_sh = 27'd1;
        else xs_sh = (xs >> d) | {26'd0, |(xs & ((27'd1 << d) - 27'd1))};
        if (big[31] ^ sml[31]) s28 = {1'b0, xl} - {1'b0, xs_sh};
        else s28 = {1'b0, xl} + {1'b0, xs_sh};
        if (s28 == 28'd0) return 32'd0;
        e = $signed({2'b00, big[30:23]});
        if (s28[27]) begin
            m27 = {s28[27:2], |s28[1:0]};
            e   = e + 10'sd1;
        end else begin
            lz = 5'd0;
            for (int i = 0; i < 27; i++) if (s28[i]) lz = 5'(26 - i);
            m27 = s28[26:0] << lz;
            e   = e - $signed({5'd0, lz});
        end
        if (e <= 10'sd0) return 32'd0;
        m25  = {1'b0, m27[26:3]} + {24'd0, m27[2] & (m27[1] | m27[0] | m27[3])};
        frac = m25[24] ? m25[23:1] : m25[22:0];
        if (m25[24]) e = e + 10'sd1;
        if (e >= 10'sd255) return {big[31], 8'hFF, 23'd0};
        return {big[31], e[7:0], frac};
    endfunction

    assign lines = {line_6_in, line_5_in, line_4_in, line_3_in, line_2_in, line_1_in, line_0_in};

    always_comb begin
        in_nan = 1'b0;
        win_in = '0;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                win_in[r][c] = lines[r][223-32*c -: 32];
                in_nan       = in_nan | (&win_in[r][c][30:23]);
            end
        end
    end

    // The center pixel sits on both diagonals, so its weights cancel to zero.
    always_comb begin
        x        = win_q[r_q][c_q];
        diag     = (r_q == c_q);
        anti     = ({1'b0, r_q} + {1'b0, c_q}) == 4'd6;
        use_w[0] = 1'b1;         neg_w[0] = 1'b0;
        use_w[1] = (r_q != 3'd3); neg_w[1] = (r_q >= 3'd4);
        use_w[2] = (c_q != 3'd3); neg_w[2] = (c_q >= 3'd4);
        use_w[3] = diag ^ anti;  neg_w[3] = anti;
        for (int k = 0; k < 4; k++)
            acc_d[k] = use_w[k] ? fp_add(acc_q[k], {x[31] ^ neg_w[k], x[30:0]}) : acc_q[k];
    end

    // r_q == 7 marks the cycle after the last element: publish, then recapture or idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            r_q     <= 3'd0;
            c_q     <= 3'd0;
            nan_q   <= 1'b0;
            acc_q   <= '0;
            sym_q   <= '0;
        end else if (state_q == IDLE || r_q == 3'd7) begin
            if (state_q == ACC) sym_q <= nan_q ? {4{32'h7FC00000}} : acc_q;
            if (de_in) begin
                state_q <= ACC;
                win_q   <= win_in;
                nan_q   <= in_nan;
                acc_q   <= '0;
                r_q     <= 3'd0;
                c_q     <= 3'd0;
            end else begin
                state_q <= IDLE;
            end
        end else begin
            acc_q <= acc_d;
            if (c_q == 3'd6) begin
                c_q <= 3'd0;
                r_q <= r_q + 3'd1;
            end else begin
                c_q <= c_q + 3'd1;
            end
        end
    end

    assign symbol_0 = sym_q[0];
    assign symbol_1 = sym_q[1];
    assign symbol_2 = sym_q[2];
    assign symbol_3 = sym_q[3];
endmodule

// File: tb/tb_neuron_unit_fp.sv
// Bench for neuron_unit_fp: exact-integer reference model with per-step binary32
// rounding, scheduled expectations, and a compare process on every falling edge.
module tb_neuron_unit_fp;
    typedef logic [31:0] win_t [0:6][0:6];
    typedef logic [3:0][31:0] res_t;
    typedef struct { int due; res_t v; } pend_t;

    logic         clk = 1'b0, reset = 1'b1, de_in = 1'b0;
    logic [223:0] ln [0:6];
    logic [31:0]  symbol_0, symbol_1, symbol_2, symbol_3;

    pend_t q[$];
    res_t  exp_q = '0;
    int    cyc = 0, vectors = 0, miscompares = 0, prints = 0;

    neuron_unit_fp dut (
        .clk(clk), .reset(reset), .de_in(de_in),
        .line_0_in(ln[0]), .line_1_in(ln[1]), .line_2_in(ln[2]), .line_3_in(ln[3]),
        .line_4_in(ln[4]), .line_5_in(ln[5]), .line_6_in(ln[6]),
        .symbol_0(symbol_0), .symbol_1(symbol_1), .symbol_2(symbol_2), .symbol_3(symbol_3)
    );

    always #5 clk = ~clk;

    // Value of a normal binary32 as a signed integer in units of 2^-149.
    function automatic logic signed [299:0] to_int(logic [31:0] f);
        logic signed [299:0] n;
        if (f[30:23] == 8'd0) return '0;
        n = 300'({1'b1, f[22:0]});
        n = n <<< (int'(f[30:23]) - 1);
        return f[31] ? -n : n;
    endfunction

    function automatic logic [31:0] to_f32(logic signed [299:0] n);
        logic [299:0] mag, rem, half;
        logic [24:0]  m;
        int p, sh, e;
        if (n == 0) return 32'd0;
        mag = (n < 0) ? -n : n;
        p = -1;
        for (int i = 299; i >= 0; i--) if (mag[i]) begin p = i; break; end
        if (p <= 22) return 32'd0;
        sh   = p - 23;
        m    = 25'(mag >> sh);
        rem  = mag - (300'(m) << sh);
        half = (sh > 0) ? (300'(1) << (sh - 1)) : '0;
        if (sh > 0 && (rem > half || (rem == half && m[0]))) m = m + 25'd1;
        e = p - 22;
        if (m[24]) begin m = m >> 1; e++; end
        if (e >= 255) return {n < 0, 8'hFF, 23'd0};
        return {n < 0, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] ref_add(logic [31:0] a, logic [31:0] b);
        if (&a[30:23]) return a;
        if (&b[30:23]) return b;
        return to_f32(to_int(a) + to_int(b));
    endfunction

    function automatic res_t model(win_t w);
        res_t acc = '0;
        bit   nan = 0;
        int   wt[4];
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                nan   = nan | (&w[r][c][30:23]);
                wt[0] = 1;
                wt[1] = (r <= 2) ? 1 : (r >= 4) ? -1 : 0;
                wt[2] = (c <= 2) ? 1 : (c >= 4) ? -1 : 0;
                wt[3] = (r == c && r + c != 6) ? 1 : (r + c == 6 && r != c) ? -1 : 0;
                for (int k = 0; k < 4; k++)
                    if (wt[k] != 0) acc[k] = ref_add(acc[k], (wt[k] < 0) ? (w[r][c] ^ 32'h80000000) : w[r][c]);
            end
        end
        return nan ? {4{32'h7FC00000}} : acc;
    endfunction

    function automatic logic [31:0] rnd_elem(int mode);
        int sel = $urandom_range(0, 19);
        case (mode)
            1: return {sel >= 16, 8'($urandom_range(248, 254)), 23'($urandom)};
            2: return {1'($urandom), 8'($urandom_range(127, 130)), 3'($urandom), 20'd0};
            default: begin
                if (sel == 0) return 32'd0;
                if (sel == 1) return {1'($urandom), 8'd0, 23'($urandom)};
                return {1'($urandom), 8'($urandom_range(118, 136)), 23'($urandom)};
            end
        endcase
    endfunction

    task automatic drive(win_t w);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) ln[r][223-32*c -: 32] = w[r][c];
    endtask

    task automatic rnd_lines();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) ln[r][223-32*c -: 32] = $urandom;
    endtask

    task automatic capture(win_t w);
        pend_t p;
        @(negedge clk);
        drive(w);
        de_in = 1'b1;
        @(posedge clk);
        #1;
        p.due = cyc + 50;
        p.v   = model(w);
        q.push_back(p);
    endtask

    // de mode: 0 low, 1 held high, 2 random; lines are scrambled while the DUT accumulates.
    task automatic fill(int n, int de_mode);
        repeat (n) begin
            @(negedge clk);
            de_in = (de_mode == 2) ? 1'($urandom) : (de_mode == 1);
            rnd_lines();
        end
    endtask

    task automatic pin(string name, res_t got, res_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL model_%s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_q = q[0].v;
                void'(q.pop_front());
            end
        end
    end

    initial begin
        res_t dut_v;
        forever begin
            @(negedge clk);
            dut_v = {symbol_3, symbol_2, symbol_1, symbol_0};
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (dut_v[k] !== exp_q[k]) begin
                    miscompares++;
                    if (prints < 40) begin
                        prints++;
                        $display("FAIL symbol_%0d cyc %0d: got %h want %h", k, cyc, dut_v[k], exp_q[k]);
                    end
                end
            end
        end
    end

    initial begin
        win_t w;
        res_t want;
        for (int r = 0; r < 7; r++) ln[r] = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({symbol_3, symbol_2, symbol_1, symbol_0} !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", {symbol_3, symbol_2, symbol_1, symbol_0});
        end
        reset = 1'b0;

        foreach (w[r, c]) w[r][c] = 32'h3F800000;
        want = {32'd0, 32'd0, 32'd0, 32'h42440000};
        pin("all_ones", model(w), want);
        capture(w); fill(49, 0); fill(3, 0);

        foreach (w[r, c]) w[r][c] = (r <= 2) ? 32'h3F800000 : 32'd0;
        pin("rows012", model(w), {32'd0, 32'd0, 32'h41A80000, 32'h41A80000});
        capture(w); fill(49, 2); fill(2, 0);

        foreach (w[r, c]) w[r][c] = (c == 0) ? 32'h40000000 : 32'd0;
        pin("col0", model(w), {32'd0, 32'h41600000, 32'd0, 32'h41600000});
        capture(w); fill(49, 2); fill(2, 0);

        foreach (w[r, c]) w[r][c] = (r == 0 && c == 0) ? 32'h437F0000 : 32'd0;
        pin("corner255", model(w), {4{32'h437F0000}});
        capture(w); fill(49, 0); fill(2, 0);

        foreach (w[r, c]) w[r][c] = (r == 3 && c == 3) ? 32'h7F800000 : 32'd0;
        pin("center_inf", model(w), {4{32'h7FC00000}});
        capture(w); fill(49, 0); fill(2, 0);

        foreach (w[r, c]) w[r][c] = 32'd0;
        pin("zeros", model(w), '0);
        capture(w); fill(49, 1);
        foreach (w[r, c]) w[r][c] = 32'h3F800000;
        capture(w); fill(49, 0); fill(2, 0);

        // Abort a frame partway through; outputs must drop at once and stay 0.
        foreach (w[r, c]) w[r][c] = 32'h40400000;
        capture(w); fill(21, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        q.delete();
        exp_q = '0;
        #1;
        vectors++;
        if ({symbol_3, symbol_2, symbol_1, symbol_0} !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_abort: got %h want 0", {symbol_3, symbol_2, symbol_1, symbol_0});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        fill(60, 0);

        for (int i = 0; i < 16; i++) begin
            foreach (w[r, c]) w[r][c] = rnd_elem(i % 3);
            if (i % 4 == 3) w[$urandom_range(0, 6)][$urandom_range(0, 6)] = {1'($urandom), 8'hFF, 23'($urandom)};
            capture(w);
            fill(49, 2);
            if ($urandom_range(0, 1) == 1) fill($urandom_range(1, 4), 0);
        end
        fill(55, 0);

        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_drain: got %0d outstanding want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
